safe_pin_ctrl: RTL and testbench

SAFE_PIN_CTRL -- requirements
Module: safe_pin_ctrl

---
 rtl/safe_pin_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_safe_pin_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_pin_ctrl.sv
// Safe PIN controller: SETUP stores a DIGITS-long PIN, LOCKED checks complete entries against it,
// OPEN scrolls the PIN on a 7-segment display, ALARM ignores input for a lockout period.
module safe_pin_ctrl #(
  parameter int DIGITS      = 3,
  parameter int MAX_TRIES   = 3,
  parameter int SECONDS     = 50_000_000,
  parameter int SHOW_SEC    = 2,
  parameter int LOCKOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       lock,
  input  logic [3:0] data,
  output logic [1:0] state,
  output logic [3:0] disp_digit,
  output logic [3:0] entered,
  output logic [3:0] tries,
  output logic       alarm,
  output logic [6:0] seg
);

  localparam int W        = DIGITS * 4;
  localparam int SHOW_CYC = SHOW_SEC * SECONDS;
  localparam int LOCK_CYC = LOCKOUT_SEC * SECONDS;
  localparam int MAX_CYC  = (SHOW_CYC > LOCK_CYC) ? SHOW_CYC : LOCK_CYC;
  localparam int TW       = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    ST_ALARM  = 2'b00,
    ST_SETUP  = 2'b01,
    ST_LOCKED = 2'b10,
    ST_OPEN   = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    pin_q, pin_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [3:0]      entered_q, entered_d;
  logic [3:0]      tries_q, tries_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      last_q, last_d;
  logic            full;
  logic [3:0]      tries_inc;

  assign full      = (entered_q == 4'(DIGITS));
  assign tries_inc = tries_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SETUP;
      pin_q     <= '0;
      buf_q     <= '0;
      entered_q <= '0;
      tries_q   <= '0;
      timer_q   <= '0;
      idx_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      buf_q     <= buf_d;
      entered_q <= entered_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

  // lock always wins over a simultaneous enter; the enter is dropped
  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    buf_d     = buf_q;
    entered_d = entered_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    last_d    = last_q;
    unique case (state_q)
      ST_SETUP: begin
        if (lock) begin
          if (full) begin
            state_d   = ST_LOCKED;
            entered_d = '0;
            buf_d     = '0;
          end
        end else if (enter) begin
          pin_d  = W'({pin_q, data});
          last_d = data;
          if (!full) entered_d = entered_q + 4'd1;
        end
      end
      ST_LOCKED: begin
        if (full) begin
          entered_d = '0;
          buf_d     = '0;
          if (buf_q == pin_q) begin
            state_d = ST_OPEN;
            tries_d = '0;
            idx_d   = '0;
            timer_d = '0;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == 4'(MAX_TRIES)) begin
              state_d = ST_ALARM;
              timer_d = '0;
            end
          end
        end else if (enter && !lock) begin
          buf_d     = W'({buf_q, data});
          entered_d = entered_q + 4'd1;
        end
      end
      ST_OPEN: begin
        if (lock) begin
          state_d   = ST_LOCKED;
          entered_d = '0;
          buf_d     = '0;
        end else if (enter) begin
          state_d   = ST_SETUP;
          entered_d = '0;
        end else if (timer_q == TW'(SHOW_CYC - 1)) begin
          timer_d = '0;
          idx_d   = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ALARM: begin
        if (timer_q == TW'(LOCK_CYC - 1)) begin
          state_d = ST_LOCKED;
          tries_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_SETUP;
    endcase
  end

  // display index 0 is the oldest digit, which sits at the top of the shift register
  always_comb begin
    disp_digit = 4'd0;
    unique case (state_q)
      ST_SETUP: disp_digit = last_q;
      ST_OPEN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == 3'(i)) disp_digit = pin_q[(DIGITS-1-i)*4 +: 4];
        end
      end
      default: disp_digit = 4'd0;
    endcase
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_comb begin
    seg = 7'h7F;
    unique case (state_q)
      ST_SETUP, ST_OPEN: seg = hex_glyph(disp_digit);
      ST_LOCKED:         seg = 7'h3F;
      default:           seg = 7'h00;
    endcase
  end

  assign state   = state_q;
  assign entered = entered_q;
  assign tries   = tries_q;
  assign alarm   = (state_q == ST_ALARM);

endmodule

// File: tb/tb_safe_pin_ctrl.sv
// Bench for safe_pin_ctrl: directed scenarios then random presses, scored against a
// queue-based reference model of the safe's behaviour.
module tb_safe_pin_ctrl;

  localparam int DIGITS      = 3;
  localparam int MAX_TRIES   = 2;
  localparam int SECONDS     = 4;
  localparam int SHOW_SEC    = 1;
  localparam int LOCKOUT_SEC = 2;
  localparam int SHOW_CYC    = SHOW_SEC * SECONDS;
  localparam int LOCK_CYC    = LOCKOUT_SEC * SECONDS;

  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enter = 1'b0;
  logic       lock = 1'b0;
  logic [3:0] data = 4'd0;
  logic [1:0] state;
  logic [3:0] disp_digit;
  logic [3:0] entered;
  logic [3:0] tries;
  logic       alarm;
  logic [6:0] seg;

  safe_pin_ctrl #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .SECONDS(SECONDS),
    .SHOW_SEC(SHOW_SEC), .LOCKOUT_SEC(LOCKOUT_SEC)
  ) dut (
    .clk(clk), .rst(rst), .enter(enter), .lock(lock), .data(data),
    .state(state), .disp_digit(disp_digit), .entered(entered), .tries(tries),
    .alarm(alarm), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] disp;
    logic [3:0] ent;
    logic [3:0] tr;
    logic       al;
    logic [6:0] sg;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // reference model: mode uses the output codes (1 SETUP, 2 LOCKED, 3 OPEN, 0 ALARM)
  int m_mode, m_tries, m_age, m_last;
  int m_pin[$];
  int m_buf[$];

  task automatic m_reset();
    m_mode = 1; m_tries = 0; m_age = 0; m_last = 0;
    m_pin = {};
    for (int i = 0; i < DIGITS; i++) m_pin.push_back(0);
    m_buf = {};
  endtask

  function automatic bit entry_matches();
    for (int i = 0; i < DIGITS; i++) if (m_buf[i] != m_pin[i]) return 1'b0;
    return 1'b1;
  endfunction

  int m_setup_cnt;

  function automatic int m_entered();
    if (m_mode == 1) return m_setup_cnt;
    if (m_mode == 2) return m_buf.size();
    return 0;
  endfunction

  task automatic m_step(input bit en, input bit lk, input int d);
    case (m_mode)
      1: begin
        if (lk) begin
          if (m_setup_cnt == DIGITS) begin m_mode = 2; m_buf = {}; end
        end else if (en) begin
          void'(m_pin.pop_front());
          m_pin.push_back(d);
          m_last = d;
          if (m_setup_cnt < DIGITS) m_setup_cnt++;
        end
      end
      2: begin
        if (m_buf.size() == DIGITS) begin
          if (entry_matches()) begin
            m_mode = 3; m_tries = 0; m_age = 0;
          end else begin
            m_tries++;
            if (m_tries == MAX_TRIES) begin m_mode = 0; m_age = 0; end
          end
          m_buf = {};
        end else if (en && !lk) begin
          m_buf.push_back(d);
        end
      end
      3: begin
        if (lk) begin m_mode = 2; m_buf = {}; end
        else if (en) begin m_mode = 1; m_setup_cnt = 0; end
        else m_age++;
      end
      default: begin
        m_age++;
        if (m_age == LOCK_CYC) begin m_mode = 2; m_tries = 0; end
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   dd;
    dd = 0;
    if (m_mode == 1) dd = m_last;
    else if (m_mode == 3) dd = m_pin[(m_age / SHOW_CYC) % DIGITS];
    e.st   = 2'(m_mode);
    e.disp = 4'(dd);
    e.ent  = 4'(m_entered());
    e.tr   = 4'(m_tries);
    e.al   = (m_mode == 0);
    if (m_mode == 1 || m_mode == 3) e.sg = ~SEG_ON[dd];
    else if (m_mode == 2)           e.sg = 7'h3F;
    else                            e.sg = 7'h00;
    return e;
  endfunction

  task automatic step(input bit en, input bit lk, input logic [3:0] d, input bit rpulse);
    @(negedge clk);
    enter = en; lock = lk; data = d; rst = 1'b1;
    if (rpulse) begin
      rst = 1'b0;
      #2;
      rst = 1'b1;
      m_reset();
      m_setup_cnt = 0;
    end
    m_step(en, lk, int'(d));
    exp_q.push_back(model_out());
  endtask

  task automatic press(input logic [3:0] d);
    step(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic cmp(input string name, input int v, input int act, input int want);
    if (act != want) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %0h, expected %0h", v, name, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        e = exp_q.pop_front();
        vectors++;
        cmp("state", vectors, int'(state), int'(e.st));
        cmp("disp_digit", vectors, int'(disp_digit), int'(e.disp));
        cmp("entered", vectors, int'(entered), int'(e.ent));
        cmp("tries", vectors, int'(tries), int'(e.tr));
        cmp("alarm", vectors, int'(alarm), int'(e.al));
        cmp("seg", vectors, int'(seg), int'(e.sg));
      end
    end
  end

  initial begin : stimulus
    bit         en, lk;
    int         r;
    logic [3:0] d;
    m_reset();
    m_setup_cnt = 0;
    exp_q.push_back(model_out());

    // set PIN 1,2,3, lock, open it, watch the display scroll
    press(4'd1); press(4'd2); press(4'd3);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    press(4'd1); press(4'd2); press(4'd3);
    idle(1);
    idle(14);
    // back to SETUP, premature lock ignored, new PIN 5,6,7
    press(4'd9);
    press(4'd5); press(4'd6);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    press(4'd7);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    // two wrong entries, second with an enter in the compare cycle
    press(4'd0); press(4'd0); press(4'd0); idle(1);
    press(4'd0); press(4'd0); press(4'd0);
    step(1'b1, 1'b0, 4'd4, 1'b0);
    step(1'b1, 1'b0, 4'd5, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    idle(8);
    // open, then enter+lock together relocks
    press(4'd5); press(4'd6); press(4'd7); idle(1);
    idle(2);
    step(1'b1, 1'b1, 4'd3, 1'b0);
    // alarm again, reset pulse mid-alarm discards the PIN
    press(4'd1); press(4'd1); press(4'd1); idle(1);
    press(4'd1); press(4'd1); press(4'd1); idle(1);
    idle(3);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    press(4'd0); press(4'd0); press(4'd0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    press(4'd5); press(4'd6); press(4'd7); idle(1);
    idle(2);

    for (int c = 0; c < 3000; c++) begin
      r  = int'($urandom_range(0, 99));
      en = 1'b0; lk = 1'b0;
      if (m_mode == 3) begin
        en = (r < 5);
        lk = (r >= 5 && r < 10) || (r >= 97);
        en = en || (r >= 97);
      end else begin
        en = (r < 40);
        lk = (r >= 40 && r < 52);
      end
      d = 4'($urandom_range(0, 15));
      if (m_mode == 2 && m_buf.size() < DIGITS && $urandom_range(0, 3) != 0)
        d = 4'(m_pin[m_buf.size()]);
      step(en, lk, d, ($urandom_range(0, 499) == 0));
    end

    @(posedge clk);
    #3;
    done = 1'b1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
